// File: rtl/pbuff_pkg.sv
// Shared types and sizes for the pixel-buffer write arbiter.
// Optional clipping of fill corners is enabled by PBA_CLIP_EN.
package pbuff_pkg;
   localparam int H_RES     = 160;
   localparam int V_RES     = 120;
   localparam int ADR_W     = 15;
   localparam int DATA_W    = 4;
   localparam int PIX_COUNT = H_RES * V_RES;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } fill_st_e;

   typedef logic [7:0] x_t;
   typedef logic [6:0] y_t;

   localparam x_t X_MAX = x_t'(H_RES - 1);
   localparam y_t Y_MAX = y_t'(V_RES - 1);

   // Linear address of the first pixel in row y: y*160 = y*128 + y*32.
   function automatic logic [ADR_W-1:0] row_of(y_t y);
      return ADR_W'({y, 7'b0}) + ADR_W'({y, 5'b0});
   endfunction
endpackage

// File: rtl/pbuff_fill_walker.sv
// Raster walker for the fill engine: x/y/row_base counters.
// Emits the current linear address and flags the last pixel.
module pbuff_fill_walker
   import pbuff_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             step_i,
   input  x_t               xmin_i,
   input  x_t               xmax_i,
   input  y_t               ymin_i,
   input  y_t               ymax_i,
   output logic [ADR_W-1:0] adr_o,
   output logic             last_o
);
   x_t xmin_q, xmin_d;
   x_t xmax_q, xmax_d;
   y_t ymax_q, ymax_d;
   x_t x_q, x_d;
   y_t y_q, y_d;
   logic [ADR_W-1:0] row_q, row_d;

   // Load bounds on start; advance left-to-right, top-to-bottom on step.
   always_comb begin
      xmin_d = xmin_q;
      xmax_d = xmax_q;
      ymax_d = ymax_q;
      x_d    = x_q;
      y_d    = y_q;
      row_d  = row_q;
      if (load_i) begin
         xmin_d = xmin_i;
         xmax_d = xmax_i;
         ymax_d = ymax_i;
         x_d    = xmin_i;
         y_d    = ymin_i;
         row_d  = row_of(ymin_i);
      end else if (step_i) begin
         if (x_q < xmax_q) begin
            x_d = x_q + 8'd1;
         end else begin
            x_d   = xmin_q;
            y_d   = y_q + 7'd1;
            row_d = row_q + ADR_W'(H_RES);
         end
      end
   end

   // Counter state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         xmin_q <= '0;
         xmax_q <= '0;
         ymax_q <= '0;
         x_q    <= '0;
         y_q    <= '0;
         row_q  <= '0;
      end else begin
         xmin_q <= xmin_d;
         xmax_q <= xmax_d;
         ymax_q <= ymax_d;
         x_q    <= x_d;
         y_q    <= y_d;
         row_q  <= row_d;
      end
   end

   assign adr_o  = row_q + ADR_W'(x_q);
   assign last_o = (x_q == xmax_q) && (y_q == ymax_q);
endmodule

// File: rtl/pbuff_write_arbiter.sv
// Single write port of the pixel buffer shared by CPU and fill engine.
// PBA_CLIP_EN: clamp out-of-range fill corners instead of rejecting.
module pbuff_write_arbiter
   import pbuff_pkg::*;
(
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [ADR_W-1:0]  cpu_adr,
   input  logic [DATA_W-1:0] cpu_data,
   input  logic              cpu_wren,
   input  logic              fill_start,
   input  logic              fill_abort,
   input  logic [7:0]        fill_x0,
   input  logic [7:0]        fill_x1,
   input  logic [6:0]        fill_y0,
   input  logic [6:0]        fill_y1,
   input  logic [DATA_W-1:0] fill_colour,
   output logic              fill_busy,
   output logic              fill_done,
   output logic              fill_err,
   output logic [ADR_W-1:0]  pbuff_adr,
   output logic [DATA_W-1:0] pbuff_data,
   output logic              pbuff_wren
);
   fill_st_e state_q, state_d;
   logic cwren_q, pend_q, pend_d, rise;
   logic [ADR_W-1:0] cadr_q, cadr_d;
   logic [DATA_W-1:0] cdat_q, cdat_d;
   logic [DATA_W-1:0] col_q, col_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic wren_q, wren_d;
   logic busy_q, busy_d, done_q, done_d;
   logic err_q, err_d;
   logic load, step, last, bad;
   logic [ADR_W-1:0] walk_adr;
   x_t xa, xb, xmin, xmax;
   y_t ya, yb, ymin, ymax;

   assign rise = cpu_wren & ~cwren_q;

   // Corner conditioning: clamp or range-check, then order.
   always_comb begin
`ifdef PBA_CLIP_EN
      xa  = (fill_x0 > X_MAX) ? X_MAX : fill_x0;
      xb  = (fill_x1 > X_MAX) ? X_MAX : fill_x1;
      ya  = (fill_y0 > Y_MAX) ? Y_MAX : fill_y0;
      yb  = (fill_y1 > Y_MAX) ? Y_MAX : fill_y1;
      bad = 1'b0;
`else
      xa  = fill_x0;
      xb  = fill_x1;
      ya  = fill_y0;
      yb  = fill_y1;
      bad = (fill_x0 > X_MAX) | (fill_x1 > X_MAX) |
            (fill_y0 > Y_MAX) | (fill_y1 > Y_MAX);
`endif
      xmin = (xa < xb) ? xa : xb;
      xmax = (xa < xb) ? xb : xa;
      ymin = (ya < yb) ? ya : yb;
      ymax = (ya < yb) ? yb : ya;
   end

   // CPU edge capture; pending clears when the port is granted.
   always_comb begin
      pend_d = pend_q;
      cadr_d = cadr_q;
      cdat_d = cdat_q;
      if (rise) begin
         pend_d = 1'b1;
         cadr_d = cpu_adr;
         cdat_d = cpu_data;
      end else if (pend_q) begin
         pend_d = 1'b0;
      end
   end

   // Fill FSM and port arbitration; CPU wins any cycle it is pending.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      wren_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      if (pend_q) begin
         wren_d = 1'b1;
         adr_d  = cadr_q;
         dat_d  = cdat_q;
      end
      unique case (state_q)
         IDLE: begin
            if (fill_start) begin
               if (bad) begin
                  err_d = 1'b1;
               end else begin
                  load    = 1'b1;
                  col_d   = fill_colour;
                  state_d = FILL;
               end
            end
         end
         FILL: begin
            if (fill_abort) begin
               state_d = IDLE;
            end else if (!pend_q) begin
               wren_d = 1'b1;
               adr_d  = walk_adr;
               dat_d  = col_q;
               step   = 1'b1;
               if (last) state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q <= IDLE;
         cwren_q <= 1'b0;
         pend_q  <= 1'b0;
         cadr_q  <= '0;
         cdat_q  <= '0;
         col_q   <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         wren_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cwren_q <= cpu_wren;
         pend_q  <= pend_d;
         cadr_q  <= cadr_d;
         cdat_q  <= cdat_d;
         col_q   <= col_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         wren_q  <= wren_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   pbuff_fill_walker u_walk (
      .clk_i  (clk_clk),
      .rst_ni (reset_reset_n),
      .load_i (load),
      .step_i (step),
      .xmin_i (xmin),
      .xmax_i (xmax),
      .ymin_i (ymin),
      .ymax_i (ymax),
      .adr_o  (walk_adr),
      .last_o (last)
   );

   assign fill_busy  = busy_q;
   assign fill_done  = done_q;
   assign fill_err   = err_q;
   assign pbuff_adr  = adr_q;
   assign pbuff_data = dat_q;
   assign pbuff_wren = wren_q;
endmodule

// File: tb/tb_pbuff_write_arbiter.sv
// Directed bench for pbuff_write_arbiter.
// Expectations for PBA_CLIP_EN builds follow the same macro.
module tb_pbuff_write_arbiter;
   import pbuff_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADR_W-1:0]  cpu_adr;
   logic [DATA_W-1:0] cpu_data;
   logic              cpu_wren;
   logic              fill_start, fill_abort;
   logic [7:0]        fill_x0, fill_x1;
   logic [6:0]        fill_y0, fill_y1;
   logic [DATA_W-1:0] fill_colour;
   logic              fill_busy, fill_done, fill_err;
   logic [ADR_W-1:0]  pbuff_adr;
   logic [DATA_W-1:0] pbuff_data;
   logic              pbuff_wren;

   int errs = 0;
   int checks = 0;
   int wq[$];
   int dq[$];
   int eq[$];
   int done_cnt, done_at, busy_cnt, err_cnt;
   int n, first, cadr, cdat;

   pbuff_write_arbiter dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .cpu_adr       (cpu_adr),
      .cpu_data      (cpu_data),
      .cpu_wren      (cpu_wren),
      .fill_start    (fill_start),
      .fill_abort    (fill_abort),
      .fill_x0       (fill_x0),
      .fill_x1       (fill_x1),
      .fill_y0       (fill_y0),
      .fill_y1       (fill_y1),
      .fill_colour   (fill_colour),
      .fill_busy     (fill_busy),
      .fill_done     (fill_done),
      .fill_err      (fill_err),
      .pbuff_adr     (pbuff_adr),
      .pbuff_data    (pbuff_data),
      .pbuff_wren    (pbuff_wren)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_list(input string tag);
      chk({tag, ".count"}, wq.size(), eq.size());
      for (int i = 0; i < eq.size(); i++) begin
         if (i < wq.size())
            chk($sformatf("%s.adr%0d", tag, i), wq[i], eq[i]);
      end
   endtask

   task automatic run_fill(input int x0, input int x1,
                           input int y0, input int y1,
                           input int col, input int cpu_at,
                           input int abort_at, input logic abort0,
                           input int ncyc);
      fill_x0     = 8'(x0);
      fill_x1     = 8'(x1);
      fill_y0     = 7'(y0);
      fill_y1     = 7'(y1);
      fill_colour = 4'(col);
      fill_start  = 1'b1;
      fill_abort  = abort0;
      step();
      fill_start = 1'b0;
      fill_abort = 1'b0;
      wq.delete();
      dq.delete();
      done_cnt = 0;
      done_at  = -1;
      busy_cnt = 0;
      err_cnt  = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (pbuff_wren) begin
            wq.push_back(int'(pbuff_adr));
            dq.push_back(int'(pbuff_data));
         end
         if (fill_done) begin
            done_cnt++;
            done_at = c;
         end
         if (fill_err) err_cnt++;
         if (fill_busy) busy_cnt++;
         if (cpu_at >= 0 && c == cpu_at) cpu_wren = 1'b1;
         if (cpu_at >= 0 && c == cpu_at + 3) cpu_wren = 1'b0;
         fill_abort = (c == abort_at);
         step();
      end
      fill_abort = 1'b0;
      cpu_wren   = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      cpu_adr     = '0;
      cpu_data    = '0;
      cpu_wren    = 1'b0;
      fill_start  = 1'b0;
      fill_abort  = 1'b0;
      fill_x0     = '0;
      fill_x1     = '0;
      fill_y0     = '0;
      fill_y1     = '0;
      fill_colour = '0;
      step();
      step();
      chk("rst.wren", pbuff_wren, 0);
      chk("rst.adr", pbuff_adr, 0);
      chk("rst.data", pbuff_data, 0);
      chk("rst.busy", fill_busy, 0);
      chk("rst.done", fill_done, 0);
      chk("rst.err", fill_err, 0);
      rst_n = 1'b1;
      step();

      // CPU write, cpu_wren held high
      cpu_adr  = 15'd100;
      cpu_data = 4'h5;
      cpu_wren = 1'b1;
      n = 0;
      first = -1;
      cadr = 0;
      cdat = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (pbuff_wren) begin
            n++;
            if (first < 0) begin
               first = c;
               cadr = int'(pbuff_adr);
               cdat = int'(pbuff_data);
            end
         end
      end
      cpu_wren = 1'b0;
      step();
      chk("cpu.nwr", n, 1);
      chk("cpu.lat", first, 1);
      chk("cpu.adr", cadr, 100);
      chk("cpu.data", cdat, 5);

      // Basic fill (2,1)-(4,2)
      run_fill(2, 4, 1, 2, 10, -1, -1, 1'b0, 14);
      eq = '{162, 163, 164, 322, 323, 324};
      chk_list("fill");
      n = 0;
      foreach (dq[i]) if (dq[i] != 10) n++;
      chk("fill.colour", n, 0);
      chk("fill.done", done_cnt, 1);
      chk("fill.done_at", done_at, 7);
      chk("fill.busy", busy_cnt, 7);
      chk("fill.err", err_cnt, 0);

      // Swapped corners
      run_fill(4, 2, 2, 1, 10, -1, -1, 1'b0, 14);
      chk_list("swap");
      chk("swap.done_at", done_at, 7);

      // Single pixel at the far corner
      run_fill(159, 159, 119, 119, 7, -1, -1, 1'b0, 6);
      eq = '{19199};
      chk_list("single");
      chk("single.data", dq.size() > 0 ? dq[0] : -1, 7);
      chk("single.done_at", done_at, 2);

      // CPU edge during the third fill write
      cpu_adr  = 15'd500;
      cpu_data = 4'h3;
      run_fill(2, 4, 1, 2, 10, 2, -1, 1'b0, 14);
      eq = '{162, 163, 164, 500, 322, 323, 324};
      chk_list("mix");
      chk("mix.cpudata", dq.size() > 3 ? dq[3] : -1, 3);
      chk("mix.done_at", done_at, 8);
      chk("mix.busy", busy_cnt, 8);

      // Abort after two fill writes
      run_fill(2, 4, 1, 2, 10, -1, 2, 1'b0, 12);
      eq = '{162, 163};
      chk_list("abort");
      chk("abort.busy", busy_cnt, 3);
      chk("abort.done", done_cnt, 0);

      // Fill after abort, started together with an abort pulse
      run_fill(5, 5, 5, 5, 1, -1, -1, 1'b1, 6);
      eq = '{805};
      chk_list("startwin");
      chk("startwin.done", done_cnt, 1);

      // Reset mid-fill
      fill_x0 = 8'd10;
      fill_x1 = 8'd20;
      fill_y0 = 7'd10;
      fill_y1 = 7'd12;
      fill_colour = 4'hF;
      fill_start = 1'b1;
      step();
      fill_start = 1'b0;
      step();
      step();
      step();
      chk("mid.wren_pre", pbuff_wren, 1);
      rst_n = 1'b0;
      #1;
      chk("mid.wren", pbuff_wren, 0);
      chk("mid.adr", pbuff_adr, 0);
      chk("mid.data", pbuff_data, 0);
      chk("mid.busy", fill_busy, 0);
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("mid.after_wren", pbuff_wren, 0);
      chk("mid.after_busy", fill_busy, 0);

      // Out-of-range corner x1=200
      run_fill(158, 200, 0, 0, 2, -1, -1, 1'b0, 8);
`ifdef PBA_CLIP_EN
      eq = '{158, 159};
      chk_list("range");
      chk("range.err", err_cnt, 0);
      chk("range.done", done_cnt, 1);
`else
      eq = '{};
      chk_list("range");
      chk("range.err", err_cnt, 1);
      chk("range.busy", busy_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/pbuff_write_arbiter.md
Name: pbuff_write_arbiter

Overview:
Owns the single write port of the 4-bit pixel buffer and shares it between two requesters:
- The Nios II software path (pb_adr/pb_data/pbuff_wren PIO exports).
- A hardware rectangle-fill engine.

The block sits between the niosII_processor PIO outputs and the pixel-buffer RAM write port, and emits at most one registered write per clock. It removes the need for software to write large areas pixel by pixel.

Parameters:
H_RES, 160, pixels per row; linear address = y*H_RES + x
V_RES, 120, rows
ADR_W, 15, pixel-buffer address width
DATA_W, 4, pixel colour width

Ports:
clk_clk  in  1  system clock, shared with niosII_processor
reset_reset_n  in  1  asynchronous active-low reset
cpu_adr  in  ADR_W  from pb_adr_export
cpu_data  in  DATA_W  from pb_data_export
cpu_wren  in  1  from pbuff_wren_export; level signal, rising edge = one write request
fill_start  in  1  1-cycle pulse; starts a fill
fill_abort  in  1  1-cycle pulse; cancels an active fill
fill_x0, fill_x1  in  8  column corners, inclusive
fill_y0, fill_y1  in  7  row corners, inclusive
fill_colour  in  DATA_W  fill colour
fill_busy  out  1  high while the fill engine owns or awaits the port
fill_done  out  1  1-cycle pulse on normal fill completion
fill_err  out  1  1-cycle pulse when a fill is rejected
pbuff_adr  out  ADR_W  RAM write address, registered
pbuff_data  out  DATA_W  RAM write data, registered
pbuff_wren  out  1  RAM write enable, 1-cycle pulse per write

Behaviour:
- Reset state: every output is 0. FSM is IDLE, CPU pending flag is clear, cpu_wren edge register is 0. Reset is asynchronous and may assert mid-fill; the fill is lost and no further writes are issued.
- CPU path:
  - Rising edge of cpu_wren, detected against its 1-cycle delayed copy, sets pending and captures cpu_adr/cpu_data in the same cycle.
  - CPU has fixed priority: if pending, the next cycle issues the CPU write. Latency is edge sample cycle N -> pbuff_wren high in cycle N+1.
  - A new edge while pending is still set is impossible, because pending clears on grant.
  - A held-high cpu_wren produces exactly one write.
- FSM IDLE:
  - fill_start latches the corners and colour, normalising them (x0>x1 or y0>y1 are swapped).
  - Range check, without PBA_CLIP_EN: a corner with x>=H_RES or y>=V_RES is rejected. fill_err pulses next cycle, no writes are issued, and the FSM stays IDLE.
  - Otherwise x=xmin, y=ymin, row_base=ymin*H_RES (computed by multiply or shift-add, one cycle), then go to FILL. fill_busy rises the cycle after fill_start.
- FSM FILL:
  - Each cycle without a CPU grant issues a write: adr=row_base+x, data=colour.
  - After each write: if x<xmax then x++; else x=xmin, y++, row_base+=H_RES.
  - The last pixel (xmax,ymax) goes to DONE.
  - A cycle with a CPU grant stalls the counters; no pixel is skipped or duplicated.
- FSM DONE: fill_done pulses for 1 cycle, fill_busy drops in the same cycle, then go to IDLE.
- fill_start while busy is ignored.
- fill_abort in FILL: return to IDLE next cycle with fill_busy=0. No fill_done, no further fill writes. A write already issued that cycle stands.
- fill_start and fill_abort in the same cycle in IDLE: the start wins.
- A single-pixel rectangle issues 1 write. Total writes for a fill = (xmax-xmin+1)*(ymax-ymin+1).
- Addresses never exceed H_RES*V_RES-1 (19199) once a fill is accepted.

Optional Feature:
PBA_CLIP_EN
- Defined: out-of-range corners are clamped to H_RES-1 / V_RES-1 before normalisation. fill_err is tied to 0, and fills are never rejected.
- Undefined: out-of-range corners are rejected as described in Behaviour.

Decomposition:
- Shared package pbuff_pkg holds:
  - H_RES, V_RES, ADR_W, DATA_W, PIX_COUNT.
  - Fill FSM state enum (IDLE, FILL, DONE).
  - Coordinate typedefs (x_t 8-bit, y_t 7-bit).
- One sub-module, pbuff_fill_walker: the x/y/row_base counters with step/load/last outputs.
- Arbitration and the CPU edge capture stay in the top.

Test Plan:
1. CPU write: cpu_adr=100, cpu_data=0x5, cpu_wren 0->1, held high for 5 cycles -> exactly one write, adr=100 data=5, one cycle after the edge.
2. Fill (2,1)-(4,2), colour 0xA -> 6 writes at 162, 163, 164, 322, 323, 324; fill_done one cycle after the last write; busy high throughout.
3. Swapped corners (4,2)-(2,1) -> same 6 writes as scenario 2. Single pixel (159,119) -> one write at 19199.
4. CPU edge during fill at the 3rd write -> CPU write is inserted, fill stalls 1 cycle, all 6 fill addresses still appear once each, in order.
5. Abort after 2 fill writes -> no further fill writes, fill_busy=0 next cycle, no fill_done. A new fill then runs normally. Reset asserted mid-fill -> all outputs 0 immediately.
6. Corner x1=200: without PBA_CLIP_EN -> fill_err pulse and 0 writes. With PBA_CLIP_EN -> columns clamp to 159 and fill_err stays 0.
